// File: rtl/regfile_mp.sv
// Multi-port integer register file with per-register validity map and a
// pending-write scoreboard for RAW hazard detection at issue.
module regfile_mp #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NREAD  = 2,
  parameter int NWRITE = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic        [NREAD*AW-1:0]     rd_addr,
  output logic signed [NREAD*XLEN-1:0]   rd_data,
  output logic        [NREAD-1:0]        rd_busy,
  input  logic        [NWRITE-1:0]       wr_en,
  input  logic        [NWRITE*AW-1:0]    wr_addr,
  input  logic        [NWRITE*XLEN-1:0]  wr_data,
  input  logic                           rsv_en,
  input  logic        [AW-1:0]           rsv_addr,
  input  logic                           flush,
  output logic                           any_pending
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] invalid_q, invalid_d;
  logic [NREGS-1:0] pending_q, pending_d;

  // Next-state: later write ports overwrite earlier ones, so the highest index wins.
  always_comb begin
    regs_d    = regs_q;
    invalid_d = invalid_q;
    pending_d = pending_q;
    for (int r = 1; r < NREGS; r++) begin
      for (int w = 0; w < NWRITE; w++) begin
        if (wr_en[w] && (wr_addr[w*AW +: AW] == AW'(r))) begin
          regs_d[r]    = wr_data[w*XLEN +: XLEN];
          invalid_d[r] = 1'b0;
          pending_d[r] = 1'b0;
        end
      end
    end
    // A reservation outranks a same-cycle write; flush outranks both.
    if (rsv_en && (rsv_addr != '0)) begin
      pending_d[rsv_addr] = 1'b1;
    end
    if (flush) begin
      pending_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      invalid_q <= {{(NREGS-1){1'b1}}, 1'b0};
      pending_q <= '0;
    end else begin
      invalid_q <= invalid_d;
      pending_q <= pending_d;
    end
  end

  // Data array carries no reset; stale contents are hidden by the invalid map.
  always_ff @(posedge clk) begin
    if (!reset) begin
      regs_q <= regs_d;
    end
  end

  // Combinational read with optional same-cycle write forwarding.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NREAD; i++) begin
      if (!reset && (rd_addr[i*AW +: AW] != '0)) begin
        if (!invalid_q[rd_addr[i*AW +: AW]]) begin
          rd_data[i*XLEN +: XLEN] = regs_q[rd_addr[i*AW +: AW]];
        end
        rd_busy[i] = pending_q[rd_addr[i*AW +: AW]];
        if (BYPASS != 0) begin
          for (int w = 0; w < NWRITE; w++) begin
            if (wr_en[w] && (wr_addr[w*AW +: AW] == rd_addr[i*AW +: AW])) begin
              rd_data[i*XLEN +: XLEN] = wr_data[w*XLEN +: XLEN];
              rd_busy[i]              = 1'b0;
            end
          end
        end
      end
    end
  end

  assign any_pending = |pending_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one bypassing and one non-bypassing
// instance share stimulus so forwarding differences are visible side by side.
module tb_regfile_mp;
  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [2*AW-1:0]         rd_addr;
  logic [1:0]              wr_en;
  logic [2*AW-1:0]         wr_addr;
  logic [2*XLEN-1:0]       wr_data;
  logic                    rsv_en;
  logic [AW-1:0]           rsv_addr;
  logic                    flush;

  logic signed [2*XLEN-1:0] rd_data_b, rd_data_n;
  logic [1:0]               rd_busy_b, rd_busy_n;
  logic                     any_pending_b, any_pending_n;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(XLEN), .NREGS(32), .NREAD(2), .NWRITE(2), .BYPASS(1)) u_dut_b (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en),
    .rsv_addr(rsv_addr), .flush(flush), .any_pending(any_pending_b)
  );

  regfile_mp #(.XLEN(XLEN), .NREGS(32), .NREAD(2), .NWRITE(2), .BYPASS(0)) u_dut_n (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en),
    .rsv_addr(rsv_addr), .flush(flush), .any_pending(any_pending_n)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int a0, input int a1);
    rd_addr = {AW'(a1), AW'(a0)};
  endtask

  task automatic set_wr(input logic [1:0] en, input int a0, input logic [31:0] d0,
                        input int a1, input logic [31:0] d1);
    wr_en   = en;
    wr_addr = {AW'(a1), AW'(a0)};
    wr_data = {d1, d0};
  endtask

  initial begin
    reset = 1'b1; rsv_en = 1'b0; rsv_addr = '0; flush = 1'b0;
    set_rd(0, 0);
    set_wr(2'b00, 0, 0, 0, 0);
    tick();
    tick();
    reset = 1'b0;

    // Clean state after reset
    set_rd(5, 0);
    #1;
    check("rst_rd0_b", rd_data_b[31:0], 0);
    check("rst_rd1_b", rd_data_b[63:32], 0);
    check("rst_busy_b", rd_busy_b, 0);
    check("rst_pend_b", any_pending_b, 0);
    check("rst_rd0_n", rd_data_n[31:0], 0);

    // Simple write then read
    set_wr(2'b01, 5, 32'h1234, 0, 0);
    tick();
    set_wr(2'b00, 0, 0, 0, 0);
    #1;
    check("wr_x5_b", rd_data_b[31:0], 32'h1234);
    check("wr_x5_n", rd_data_n[31:0], 32'h1234);

    // Write conflict: higher port wins
    set_wr(2'b11, 7, 32'hAAAA, 7, 32'h5555);
    tick();
    set_wr(2'b00, 0, 0, 0, 0);
    set_rd(7, 5);
    #1;
    check("conf_x7_b", rd_data_b[31:0], 32'h5555);
    check("conf_x7_n", rd_data_n[31:0], 32'h5555);
    check("conf_x5_kept", rd_data_b[63:32], 32'h1234);
    set_wr(2'b01, 7, 32'hAAAA, 7, 32'h5555);
    tick();
    set_wr(2'b00, 0, 0, 0, 0);
    #1;
    check("p0only_x7", rd_data_b[31:0], 32'hAAAA);

    // Same-cycle bypass vs committed-only read of an invalid register
    set_rd(3, 0);
    set_wr(2'b01, 3, 32'hDEAD, 0, 0);
    #1;
    check("byp_x3_b", rd_data_b[31:0], 32'hDEAD);
    check("byp_x3_n", rd_data_n[31:0], 0);
    tick();
    set_wr(2'b00, 0, 0, 0, 0);
    #1;
    check("post_x3_b", rd_data_b[31:0], 32'hDEAD);
    check("post_x3_n", rd_data_n[31:0], 32'hDEAD);

    // Reservation and its clearing write
    rsv_en = 1'b1; rsv_addr = 5'd9;
    tick();
    rsv_en = 1'b0;
    set_rd(0, 9);
    #1;
    check("rsv_busy_b", rd_busy_b, 2'b10);
    check("rsv_pend_b", any_pending_b, 1);
    check("rsv_busy_n", rd_busy_n, 2'b10);
    set_wr(2'b10, 0, 0, 9, 32'd7);
    #1;
    check("wrbusy_fwd_b", rd_busy_b, 2'b00);
    check("wrbusy_fwd_n", rd_busy_n, 2'b10);
    tick();
    set_wr(2'b00, 0, 0, 0, 0);
    #1;
    check("clr_busy_b", rd_busy_b, 2'b00);
    check("clr_busy_n", rd_busy_n, 2'b00);
    check("clr_x9", rd_data_b[63:32], 32'd7);
    check("clr_pend", any_pending_b, 0);

    // Reserve and write same register in one cycle: reservation wins
    rsv_en = 1'b1; rsv_addr = 5'd9;
    set_wr(2'b01, 9, 32'd8, 0, 0);
    tick();
    rsv_en = 1'b0;
    set_wr(2'b00, 0, 0, 0, 0);
    #1;
    check("rsvwr_busy_b", rd_busy_b, 2'b10);
    check("rsvwr_busy_n", rd_busy_n, 2'b10);
    check("rsvwr_x9", rd_data_b[63:32], 32'd8);

    // Flush beats a simultaneous reservation
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    check("flush0_pend", any_pending_b, 0);
    rsv_en = 1'b1; rsv_addr = 5'd4;
    tick();
    rsv_addr = 5'd6;
    tick();
    rsv_addr = 5'd8;
    tick();
    rsv_en = 1'b0;
    set_rd(4, 8);
    #1;
    check("multi_busy", rd_busy_b, 2'b11);
    check("multi_pend", any_pending_b, 1);
    flush = 1'b1; rsv_en = 1'b1; rsv_addr = 5'd10;
    tick();
    flush = 1'b0; rsv_en = 1'b0;
    #1;
    check("flush_busy", rd_busy_b, 2'b00);
    check("flush_pend_b", any_pending_b, 0);
    check("flush_pend_n", any_pending_n, 0);
    set_rd(10, 6);
    #1;
    check("flush_x10_x6", rd_busy_b, 2'b00);

    // Reset overrides an in-flight write
    set_wr(2'b01, 12, 32'h99, 0, 0);
    reset = 1'b1;
    set_rd(12, 5);
    #1;
    check("inrst_rd_b", rd_data_b, 0);
    tick();
    reset = 1'b0;
    set_wr(2'b00, 0, 0, 0, 0);
    #1;
    check("rstwr_x12_b", rd_data_b[31:0], 0);
    check("rstwr_x12_n", rd_data_n[31:0], 0);
    check("rst_x5_inv", rd_data_b[63:32], 0);
    check("rstwr_busy", rd_busy_b, 2'b00);

    // Register 0 ignores writes and reservations
    set_rd(0, 0);
    set_wr(2'b10, 0, 0, 0, 32'hFFFF);
    rsv_en = 1'b1; rsv_addr = 5'd0;
    #1;
    check("x0_byp", rd_data_b[31:0], 0);
    tick();
    set_wr(2'b00, 0, 0, 0, 0);
    rsv_en = 1'b0;
    #1;
    check("x0_rd_b", rd_data_b[63:32], 0);
    check("x0_rd_n", rd_data_n[31:0], 0);
    check("x0_busy", rd_busy_b, 2'b00);
    check("x0_pend", any_pending_b, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
